// File: rtl/milano_pkg.sv
// rtl/milano_pkg.sv - shared types and constants for the milano core
//
// Contents:
//   MILANO_BOOT_ADDR : default reset PC for the fetch stage
//   if_state_e       : fetch FSM states (IDLE/REQ/WAIT)
//   fetch_entry_t    : one fetch FIFO entry {addr, instr}
package milano_pkg;

    localparam logic [31:0] MILANO_BOOT_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - shift-register fetch FIFO whose head is a plain flop
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, data    : write one entry (caller guarantees a free slot or a same-cycle pop)
//   pop           : drop the head entry (caller guarantees non-empty)
//   flush         : empty the FIFO; wins over push and pop
//   head          : current head entry, driven directly by entry 0 flops
//   count, empty  : occupancy
module fetch_fifo
    import milano_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  data,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty
);

    fetch_entry_t  mem     [DEPTH];
    fetch_entry_t  shifted [DEPTH];
    logic [CW-1:0] wr_idx;

    // Entries shift toward index 0 on pop so the head never moves through a mux.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            shifted[i] = mem[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            shifted[i] = mem[i + 1];
        end
        wr_idx = pop ? count - CW'(1) : count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && wr_idx == CW'(i)) begin
                    mem[i] <= data;
                end else if (pop) begin
                    mem[i] <= shifted[i];
                end
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[0];
    assign empty = (count == '0);

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, memory handshake, fetch FIFO
//
// Parameters:
//   BOOT_ADDR  : PC after reset (word aligned)
//   FIFO_DEPTH : fetch FIFO entries, 2..4
// Ports:
//   clk_i, rst_i                        : clock, synchronous active-high reset
//   instr_req_o, instr_addr_o           : request to instruction memory
//   instr_gnt_i, instr_rvalid_i,
//   instr_rdata_i                       : memory grant and read response
//   branch_en_i, branch_target_i        : redirect from EX
//   id_ready_i                          : ID consumes the head entry
//   instr_valid_id_o, instr_rdata_id_o,
//   instr_addr_id_o                     : registered IF-ID head entry
module if_stage
    import milano_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = MILANO_BOOT_ADDR,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        branch_en_i,
    input  logic [31:0] branch_target_i,
    input  logic        id_ready_i,
    output logic        instr_valid_id_o,
    output logic [31:0] instr_rdata_id_o,
    output logic [31:0] instr_addr_id_o
);

    localparam int            CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    if_state_e     state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_addr;
    logic          drop;
    logic [31:0]   branch_pc;
    logic          push;
    logic          pop;
    logic          empty;
    logic [CW-1:0] count;
    logic [CW-1:0] next_count;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic          unused_target_lsbs;

    assign branch_pc          = {branch_target_i[31:2], 2'b00};
    assign unused_target_lsbs = ^branch_target_i[1:0];

    assign push       = (state == IF_WAIT) && instr_rvalid_i && !drop && !branch_en_i;
    assign pop        = id_ready_i && !empty;
    assign push_entry = '{addr: req_addr, instr: instr_rdata_i};
    assign next_count = branch_en_i ? '0 : count + CW'(push) - CW'(pop);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .pop   (pop),
        .flush (branch_en_i),
        .data  (push_entry),
        .head  (head),
        .count (count),
        .empty (empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IF_IDLE;
            fetch_pc <= BOOT_ADDR;
            req_addr <= BOOT_ADDR;
            drop     <= 1'b0;
        end else begin
            case (state)
                IF_IDLE: begin
                    if (branch_en_i) begin
                        fetch_pc <= branch_pc;
                        state    <= IF_REQ;
                    end else if (count < DEPTH_CNT) begin
                        state <= IF_REQ;
                    end
                end
                IF_REQ: begin
                    if (instr_gnt_i) begin
                        state <= IF_WAIT;
                        if (branch_en_i) begin
                            fetch_pc <= branch_pc;
                            drop     <= 1'b1;
                        end else if (!drop) begin
                            req_addr <= fetch_pc;
                            fetch_pc <= fetch_pc + 32'd4;
                        end
                        // drop already set: a stale request was granted and
                        // fetch_pc already holds the redirect target.
                    end else if (branch_en_i) begin
                        // The bus address must not change before gnt, so the
                        // old address is parked in req_addr and driven from there.
                        if (!drop) begin
                            req_addr <= fetch_pc;
                        end
                        fetch_pc <= branch_pc;
                        drop     <= 1'b1;
                    end
                end
                IF_WAIT: begin
                    if (instr_rvalid_i) begin
                        drop <= 1'b0;
                        if (branch_en_i) begin
                            fetch_pc <= branch_pc;
                            state    <= IF_REQ;
                        end else if (next_count < DEPTH_CNT) begin
                            state <= IF_REQ;
                        end else begin
                            state <= IF_IDLE;
                        end
                    end else if (branch_en_i) begin
                        fetch_pc <= branch_pc;
                        drop     <= 1'b1;
                    end
                end
                default: begin
                    state <= IF_IDLE;
                end
            endcase
        end
    end

    assign instr_req_o      = (state == IF_REQ);
    assign instr_addr_o     = (state == IF_REQ && drop) ? req_addr : fetch_pc;
    assign instr_valid_id_o = !empty;
    assign instr_rdata_id_o = head.instr;
    assign instr_addr_id_o  = head.addr;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

    logic        clk = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    logic        a_rst, a_req, a_gnt, a_rvalid, a_branch, a_ready, a_valid_id;
    logic [31:0] a_addr, a_rdata, a_target, a_rdata_id, a_addr_id;
    logic        b_rst, b_req, b_gnt, b_rvalid, b_branch, b_ready, b_valid_id;
    logic [31:0] b_addr, b_rdata, b_target, b_rdata_id, b_addr_id;

    always #5 clk = ~clk;

    if_stage u_dut_a (
        .clk_i            (clk),
        .rst_i            (a_rst),
        .instr_req_o      (a_req),
        .instr_addr_o     (a_addr),
        .instr_gnt_i      (a_gnt),
        .instr_rvalid_i   (a_rvalid),
        .instr_rdata_i    (a_rdata),
        .branch_en_i      (a_branch),
        .branch_target_i  (a_target),
        .id_ready_i       (a_ready),
        .instr_valid_id_o (a_valid_id),
        .instr_rdata_id_o (a_rdata_id),
        .instr_addr_id_o  (a_addr_id)
    );

    if_stage #(
        .BOOT_ADDR (32'hFFFF_FFFC)
    ) u_dut_b (
        .clk_i            (clk),
        .rst_i            (b_rst),
        .instr_req_o      (b_req),
        .instr_addr_o     (b_addr),
        .instr_gnt_i      (b_gnt),
        .instr_rvalid_i   (b_rvalid),
        .instr_rdata_i    (b_rdata),
        .branch_en_i      (b_branch),
        .branch_target_i  (b_target),
        .id_ready_i       (b_ready),
        .instr_valid_id_o (b_valid_id),
        .instr_rdata_id_o (b_rdata_id),
        .instr_addr_id_o  (b_addr_id)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset_a();
        a_rst = 1'b1; a_gnt = 1'b0; a_rvalid = 1'b0; a_rdata = '0;
        a_branch = 1'b0; a_target = '0; a_ready = 1'b0;
        tick();
        a_rst = 1'b0;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (a_req !== 1'b0 || a_addr !== 32'h0 || a_valid_id !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_a_ctrl: req=%b addr=%h valid=%b expected 0 00000000 0", a_req, a_addr, a_valid_id);
        end
        vectors++;
        if (a_rdata_id !== 32'h0 || a_addr_id !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_a_data: rdata_id=%h addr_id=%h expected 0 0", a_rdata_id, a_addr_id);
        end
        vectors++;
        if (b_req !== 1'b0 || b_addr !== 32'hFFFF_FFFC || b_valid_id !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_b_ctrl: req=%b addr=%h valid=%b expected 0 fffffffc 0", b_req, b_addr, b_valid_id);
        end
    endtask

    task automatic test_boot();
        do_reset_a();
        a_gnt = 1'b1; a_rvalid = 1'b1; a_rdata = 32'h0000_0013; a_ready = 1'b1;
        tick();  // cycle 1
        vectors++;
        if (a_req !== 1'b1 || a_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL boot_first_req: req=%b addr=%h expected 1 00000000", a_req, a_addr);
        end
        tick();  // cycle 2
        vectors++;
        if (a_req !== 1'b0 || a_valid_id !== 1'b0) begin
            miscompares++;
            $display("FAIL boot_wait: req=%b valid=%b expected 0 0", a_req, a_valid_id);
        end
        tick();  // cycle 3
        vectors++;
        if (a_valid_id !== 1'b1 || a_addr_id !== 32'h0 || a_rdata_id !== 32'h13) begin
            miscompares++;
            $display("FAIL boot_first_valid: valid=%b addr_id=%h rdata_id=%h expected 1 00000000 00000013", a_valid_id, a_addr_id, a_rdata_id);
        end
        vectors++;
        if (a_req !== 1'b1 || a_addr !== 32'h4) begin
            miscompares++;
            $display("FAIL boot_second_req: req=%b addr=%h expected 1 00000004", a_req, a_addr);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            tick();  // cycles 5, 7, 9
            vectors++;
            if (a_valid_id !== 1'b1 || a_addr_id !== 32'(4 * k)) begin
                miscompares++;
                $display("FAIL boot_stream_%0d: valid=%b addr_id=%h expected 1 %h", k, a_valid_id, a_addr_id, 32'(4 * k));
            end
        end
    endtask

    task automatic test_backpressure();
        int          nreq;
        logic [31:0] seen_addr;
        do_reset_a();
        a_gnt = 1'b1; a_rvalid = 1'b1; a_rdata = 32'h0000_0013; a_ready = 1'b0;
        repeat (5) tick();  // cycle 5: FIFO full with addr 0, 4
        vectors++;
        if (a_req !== 1'b0 || a_valid_id !== 1'b1 || a_addr_id !== 32'h0) begin
            miscompares++;
            $display("FAIL bp_full: req=%b valid=%b addr_id=%h expected 0 1 00000000", a_req, a_valid_id, a_addr_id);
        end
        repeat (2) tick();  // cycle 7
        vectors++;
        if (a_req !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold: req=%b expected 0", a_req);
        end
        a_ready = 1'b1;
        tick();  // cycle 8
        a_ready = 1'b0;
        vectors++;
        if (a_valid_id !== 1'b1 || a_addr_id !== 32'h4) begin
            miscompares++;
            $display("FAIL bp_advance: valid=%b addr_id=%h expected 1 00000004", a_valid_id, a_addr_id);
        end
        nreq = 0;
        seen_addr = 32'hFFFF_FFFF;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (a_req === 1'b1) begin
                nreq++;
                seen_addr = a_addr;
            end
        end
        vectors++;
        if (nreq !== 1 || seen_addr !== 32'h8) begin
            miscompares++;
            $display("FAIL bp_one_req: requests=%0d addr=%h expected 1 00000008", nreq, seen_addr);
        end
    endtask

    task automatic test_gnt_stall();
        do_reset_a();
        a_gnt = 1'b1; a_rvalid = 1'b1; a_rdata = 32'h0000_0013; a_ready = 1'b1;
        repeat (8) tick();  // cycle 8: waiting for addr 0xC response
        a_gnt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();  // cycles 9..12
            if (k == 3) a_gnt = 1'b1;
            vectors++;
            if (a_req !== 1'b1 || a_addr !== 32'h10) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: req=%b addr=%h expected 1 00000010", k, a_req, a_addr);
            end
        end
        tick();  // cycle 13
        vectors++;
        if (a_req !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_granted: req=%b expected 0", a_req);
        end
        tick();  // cycle 14
        vectors++;
        if (a_valid_id !== 1'b1 || a_addr_id !== 32'h10 || a_req !== 1'b1 || a_addr !== 32'h14) begin
            miscompares++;
            $display("FAIL stall_advance: valid=%b addr_id=%h req=%b addr=%h expected 1 00000010 1 00000014", a_valid_id, a_addr_id, a_req, a_addr);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset_a();
        a_gnt = 1'b1; a_rvalid = 1'b1; a_rdata = 32'h0000_0013; a_ready = 1'b1;
        repeat (4) tick();  // cycle 4
        a_ready = 1'b0;
        tick();  // cycle 5: request for 0x8
        a_rvalid = 1'b0;
        vectors++;
        if (a_req !== 1'b1 || a_addr !== 32'h8) begin
            miscompares++;
            $display("FAIL rw_req8: req=%b addr=%h expected 1 00000008", a_req, a_addr);
        end
        tick();  // cycle 6: WAIT, head holds addr 4
        vectors++;
        if (a_valid_id !== 1'b1 || a_addr_id !== 32'h4) begin
            miscompares++;
            $display("FAIL rw_pre_flush: valid=%b addr_id=%h expected 1 00000004", a_valid_id, a_addr_id);
        end
        a_branch = 1'b1; a_target = 32'h0000_0200;
        tick();  // cycle 7
        a_branch = 1'b0;
        vectors++;
        if (a_valid_id !== 1'b0) begin
            miscompares++;
            $display("FAIL rw_flushed: valid=%b expected 0", a_valid_id);
        end
        tick();  // cycle 8: stale response for 0x8 arrives
        a_rvalid = 1'b1; a_rdata = 32'hDEAD_0008;
        tick();  // cycle 9
        a_rvalid = 1'b0;
        vectors++;
        if (a_valid_id !== 1'b0 || a_req !== 1'b1 || a_addr !== 32'h200) begin
            miscompares++;
            $display("FAIL rw_target_req: valid=%b req=%b addr=%h expected 0 1 00000200", a_valid_id, a_req, a_addr);
        end
        tick();  // cycle 10
        a_rvalid = 1'b1; a_rdata = 32'h0200_0013;
        tick();  // cycle 11
        a_rvalid = 1'b0;
        vectors++;
        if (a_valid_id !== 1'b1 || a_addr_id !== 32'h200 || a_rdata_id !== 32'h0200_0013) begin
            miscompares++;
            $display("FAIL rw_target_entry: valid=%b addr_id=%h rdata_id=%h expected 1 00000200 02000013", a_valid_id, a_addr_id, a_rdata_id);
        end
    endtask

    task automatic test_redirect_req();
        do_reset_a();
        a_gnt = 1'b0; a_rvalid = 1'b1; a_rdata = 32'hBAD0_0000; a_ready = 1'b0;
        tick();  // cycle 1
        a_branch = 1'b1; a_target = 32'h0000_0103;
        tick();  // cycle 2
        a_branch = 1'b0;
        vectors++;
        if (a_req !== 1'b1 || a_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL rr_hold_old_1: req=%b addr=%h expected 1 00000000", a_req, a_addr);
        end
        tick();  // cycle 3
        a_gnt = 1'b1;
        vectors++;
        if (a_req !== 1'b1 || a_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL rr_hold_old_2: req=%b addr=%h expected 1 00000000", a_req, a_addr);
        end
        tick();  // cycle 4: stale response with rvalid held high
        vectors++;
        if (a_req !== 1'b0 || a_valid_id !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_wait_stale: req=%b valid=%b expected 0 0", a_req, a_valid_id);
        end
        tick();  // cycle 5
        a_rdata = 32'h1111_0100;
        vectors++;
        if (a_req !== 1'b1 || a_addr !== 32'h100 || a_valid_id !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_target_req: req=%b addr=%h valid=%b expected 1 00000100 0", a_req, a_addr, a_valid_id);
        end
        tick();  // cycle 6
        tick();  // cycle 7
        vectors++;
        if (a_valid_id !== 1'b1 || a_addr_id !== 32'h100 || a_rdata_id !== 32'h1111_0100) begin
            miscompares++;
            $display("FAIL rr_target_entry: valid=%b addr_id=%h rdata_id=%h expected 1 00000100 11110100", a_valid_id, a_addr_id, a_rdata_id);
        end
    endtask

    task automatic test_wrap_reset();
        b_rst = 1'b1; b_branch = 1'b0; b_target = '0;
        b_gnt = 1'b0; b_rvalid = 1'b0; b_rdata = '0; b_ready = 1'b0;
        tick();
        b_rst = 1'b0;
        b_gnt = 1'b1; b_rvalid = 1'b1; b_rdata = 32'h0000_0013; b_ready = 1'b1;
        tick();  // cycle 1
        vectors++;
        if (b_req !== 1'b1 || b_addr !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_boot: req=%b addr=%h expected 1 fffffffc", b_req, b_addr);
        end
        tick();
        tick();  // cycle 3
        b_rvalid = 1'b0;
        vectors++;
        if (b_req !== 1'b1 || b_addr !== 32'h0 || b_addr_id !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_second: req=%b addr=%h addr_id=%h expected 1 00000000 fffffffc", b_req, b_addr, b_addr_id);
        end
        tick();  // cycle 4: waiting for addr 0
        b_rst = 1'b1;
        tick();  // cycle 5
        vectors++;
        if (b_req !== 1'b0 || b_valid_id !== 1'b0 || b_addr !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_midreset: req=%b valid=%b addr=%h expected 0 0 fffffffc", b_req, b_valid_id, b_addr);
        end
        b_rst = 1'b0; b_rvalid = 1'b1; b_rdata = 32'hBAD0_0001; b_gnt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();  // cycles 6, 7: late rvalid must be ignored
            vectors++;
            if (b_req !== 1'b1 || b_addr !== 32'hFFFF_FFFC || b_valid_id !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap_late_rvalid_%0d: req=%b addr=%h valid=%b expected 1 fffffffc 0", k, b_req, b_addr, b_valid_id);
            end
        end
        b_gnt = 1'b1; b_rdata = 32'h0000_600D;
        tick();  // cycle 8
        tick();  // cycle 9
        vectors++;
        if (b_valid_id !== 1'b1 || b_addr_id !== 32'hFFFF_FFFC || b_rdata_id !== 32'h0000_600D) begin
            miscompares++;
            $display("FAIL wrap_restart: valid=%b addr_id=%h rdata_id=%h expected 1 fffffffc 0000600d", b_valid_id, b_addr_id, b_rdata_id);
        end
    endtask

    initial begin
        a_rst = 1'b1; a_gnt = 1'b0; a_rvalid = 1'b0; a_rdata = '0;
        a_branch = 1'b0; a_target = '0; a_ready = 1'b0;
        b_rst = 1'b1; b_gnt = 1'b0; b_rvalid = 1'b0; b_rdata = '0;
        b_branch = 1'b0; b_target = '0; b_ready = 1'b0;
        test_reset();
        test_boot();
        test_backpressure();
        test_gnt_stall();
        test_redirect_wait();
        test_redirect_req();
        test_wrap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage of the milano core; sits directly upstream of `id_stage` and drives its IF-ID inputs (`instr_rdata_i`, `instr_addr_i`).
- Generates the PC and runs a req/gnt/rvalid handshake to instruction memory, with at most one outstanding request.
- Buffers returned instructions in a 2-entry fetch FIFO whose head is the registered IF-ID output.
- Handles branch/jump redirects from EX by flushing the FIFO and discarding in-flight responses.

## Interface
Parameters:
- `BOOT_ADDR`, default `32'h0000_0000`: PC after reset. Bits [1:0] must be 0.
- `FIFO_DEPTH`, default `2`: fetch FIFO entries. Legal range is 2..4.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset; synchronous, active-high.
- `instr_req_o`  out  1  memory request.
- `instr_addr_o`  out  32  request address (word aligned).
- `instr_gnt_i`  in  1  request accepted this cycle.
- `instr_rvalid_i`  in  1  read data valid.
- `instr_rdata_i`  in  32  read data.
- `branch_en_i`  in  1  redirect pulse from EX.
- `branch_target_i`  in  32  redirect target; bits [1:0] are ignored (forced 0).
- `id_ready_i`  in  1  ID consumes the head entry this cycle.
- `instr_valid_id_o`  out  1  head entry valid.
- `instr_rdata_id_o`  out  32  head instruction.
- `instr_addr_id_o`  out  32  head instruction address.

## Operation
- Fetch FSM states: IDLE, REQ, WAIT.
- `instr_req_o` = (state == REQ). `instr_addr_o` = `fetch_pc`.
- **IDLE → REQ:** when occupancy < FIFO_DEPTH, no branch this cycle, and `rst_i` is low.
- **REQ:** `instr_req_o` stays high and `instr_addr_o` stays stable until `instr_gnt_i`.
  - On gnt: go to WAIT, latch `req_addr = fetch_pc`, set `fetch_pc += 4`.
  - PC wraps from `32'hFFFF_FFFC` to `0`.
- **WAIT:** on `instr_rvalid_i`:
  - If `drop` is clear, push {`req_addr`, `instr_rdata_i`}; if `drop` is set, discard the response.
  - Then clear `drop`.
  - Go to REQ if next-cycle occupancy < FIFO_DEPTH, else go to IDLE.
- `instr_rvalid_i` is ignored in IDLE and REQ.
- **Pop:** when `id_ready_i` && `instr_valid_id_o`. Push and pop in the same cycle leave occupancy unchanged.
- Occupancy never exceeds FIFO_DEPTH, because a request is issued only when a slot is free.
- **Redirect** (`branch_en_i` high at an edge):
  - FIFO is flushed (occupancy 0) and `fetch_pc` ← `{branch_target_i[31:2], 2'b00}`.
  - IDLE: next state is REQ.
  - REQ without gnt: the handshake completes on the old address; state goes to WAIT with `drop` set, and `fetch_pc` keeps the target. The in-flight gnt does not increment the PC.
  - REQ with gnt in the same cycle: go to WAIT with `drop` set.
  - WAIT without rvalid: set `drop`.
  - WAIT with rvalid in the same cycle: data is discarded, next state is REQ.
  - Flush takes priority over any simultaneous push or pop.
- **Reset:**
  - State: IDLE, `fetch_pc` = BOOT_ADDR, occupancy 0, `drop` = 0.
  - All outputs are 0, except `instr_addr_o` = BOOT_ADDR.
  - Reset mid-transaction abandons any outstanding response. A late rvalid arrives while in IDLE/REQ and is ignored.

## Timing
- First request: cycle 1 after the first edge with `rst_i` low.
- Latency with gnt in the request cycle N and rvalid in N+1: `instr_valid_id_o` is high from N+2.
- Sustained throughput: one instruction per 2 cycles with zero-wait memory.
- Redirect at edge E: `instr_valid_id_o` is low in the cycle after E. The first target instruction is valid no earlier than E+3 (REQ at E+1, rvalid at E+2).
- Outputs `instr_*_id_o` come straight from FIFO head flops; there is no combinational path from `id_ready_i`.
- `instr_req_o` depends only on state (registered). There is no combinational path from `instr_gnt_i` to `instr_req_o`.

## Structure
- `milano_pkg` gains:
  - `if_state_e` (IDLE/REQ/WAIT enum).
  - `fetch_entry_t` (packed struct {addr[31:0], instr[31:0]}).
  - `MILANO_BOOT_ADDR` constant, used as the default for `BOOT_ADDR`.
- One sub-module, `fetch_fifo`:
  - Parameterised by depth.
  - Ports: push, pop, flush, `fetch_entry_t` data in and head out, `count`, `empty`.
  - Flush has priority over push and pop.
- The FSM, PC and `drop` logic live in `if_stage`.

## Test plan
- **Reset/boot:** release reset with gnt and rvalid tied 1 and rdata `32'h00000013` → `instr_req_o` high with address 0 on cycle 1; valid_id with addr 0 and rdata `0x13` on cycle 3. Subsequent addresses are 4, 8, 12.
- **Backpressure:** hold `id_ready_i` = 0 → after 2 fetches (addr 0, 4) `instr_req_o` stays low. Raise ready for one cycle → head advances to addr 4 and exactly one new request for addr 8 is issued.
- **Gnt stall:** gnt held low 3 cycles while fetching addr `0x10` → req and address stay stable (`0x10`) for all 4 cycles and the PC advances only after gnt.
- **Redirect in WAIT:** branch to `0x200` while a request for `0x8` is outstanding and rvalid comes 2 cycles later → the `0x8` data never appears on the ID outputs; the next ID entry has addr `0x200`.
- **Redirect with unaligned target in REQ without gnt:** target `0x103` → the old address is held until gnt, its response is dropped, and the next request address is `0x100`.
- **Wrap and reset mid-flight:** BOOT_ADDR `0xFFFFFFFC` → second fetch address is `0`. Assert `rst_i` during WAIT and return rvalid after release → the response is ignored and fetch restarts at BOOT_ADDR.
